// File: rtl/dcache_port_arb_pkg.sv
// pipTypes: shared pipeline types, including the dcache port arbiter FSM state
package pipTypes;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ARB_IDLE   = 1'b0;
    localparam arb_state_t ARB_LOCKED = 1'b1;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dcache_port_arb_rr_pick.sv
// rr_pick: round-robin priority picker, first set request at or above ptr (wrapping)
module rr_pick
    import pipTypes::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic [N_REQ-1:0]         onehot
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] j;

    // scan offsets from farthest to nearest so the nearest active requester wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
    end

    assign onehot = valid ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: round-robin arbiter sharing one data-cache port among N_REQ load/store requesters
module dcache_port_arb
    import pipTypes::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_rd,
    input  logic [N_REQ-1:0]           req_wr,
    input  logic [N_REQ-1:0][31:0]     req_addr,
    input  logic [N_REQ-1:0][31:0]     req_wr_data,
    input  logic [N_REQ-1:0][3:0]      req_wr_be,
    output logic [N_REQ-1:0]           req_waitrequest,
    output logic [31:0]                req_data,
    output logic                       cache_rd,
    output logic                       cache_wr,
    output logic [31:0]                cache_addr,
    output logic [31:0]                cache_wr_data,
    output logic [3:0]                 cache_wr_be,
    input  logic [31:0]                cache_data,
    input  logic                       cache_waitrequest,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state_q;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner_q;
    logic [N_REQ-1:0] active;
    logic             win_valid;
    logic [IW-1:0]    win_idx;
    logic [N_REQ-1:0] win_oh;
    logic             locked;
    logic [IW-1:0]    sel;
    logic             gv;
    logic             done;
    logic             contend;
    logic [N_REQ-1:0] grant_oh;

    assign active = req_rd | req_wr;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (active),
        .ptr    (rr_ptr),
        .valid  (win_valid),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    // select the driving requester: the locked owner, else the fresh round-robin winner; reset masks everything
    always_comb begin
        locked   = state_q == ARB_LOCKED;
        sel      = locked ? owner_q : win_idx;
        gv       = reset_n & (locked ? active[owner_q] : win_valid);
        grant_oh = !gv ? '0 : locked ? (N_REQ'(1) << owner_q) : win_oh;
        done     = gv & ~cache_waitrequest;
        contend  = |(active & ~grant_oh);
    end

    assign grant_valid     = gv;
    assign grant_idx       = gv ? sel : '0;
    assign cache_rd        = gv & req_rd[sel] & ~req_wr[sel];
    assign cache_wr        = gv & req_wr[sel];
    assign cache_addr      = gv ? req_addr[sel] : '0;
    assign cache_wr_data   = gv ? req_wr_data[sel] : '0;
    assign cache_wr_be     = gv ? req_wr_be[sel] : '0;
    assign req_waitrequest = done ? ~grant_oh : '1;
    assign req_data        = cache_data;

    // lock the port on a stalled grant, release on completion or owner abandon, advance pointer past each completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ARB_IDLE;
            rr_ptr         <= '0;
            owner_q        <= '0;
            contention_cnt <= '0;
        end else begin
            state_q <= (gv && cache_waitrequest) ? ARB_LOCKED : ARB_IDLE;
            if (gv && cache_waitrequest) owner_q <= sel;
            if (done) rr_ptr <= IW'(rr_next(int'(sel), N_REQ));
            if (contend && !(&contention_cnt)) contention_cnt <= contention_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: directed vector table plus hand sequences for the dcache port arbiter
module tb_dcache_port_arb;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       req_rd, req_wr, req_waitrequest;
    logic [1:0][31:0] req_addr, req_wr_data;
    logic [1:0][3:0]  req_wr_be;
    logic [31:0]      req_data, cache_addr, cache_wr_data, cache_data;
    logic [3:0]       cache_wr_be;
    logic             cache_rd, cache_wr, cache_waitrequest, grant_valid;
    logic [0:0]       grant_idx;
    logic [15:0]      contention_cnt;
    int               checks = 0;
    int               failures = 0;

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        cw;
        logic [31:0] cd;
        logic [1:0]  wreq;
        logic        crd;
        logic        cwr;
        logic [31:0] addr;
        logic        gv;
        logic        gi;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[13];

    dcache_port_arb #(.N_REQ(2), .CNT_W(16)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_rd            (req_rd),
        .req_wr            (req_wr),
        .req_addr          (req_addr),
        .req_wr_data       (req_wr_data),
        .req_wr_be         (req_wr_be),
        .req_waitrequest   (req_waitrequest),
        .req_data          (req_data),
        .cache_rd          (cache_rd),
        .cache_wr          (cache_wr),
        .cache_addr        (cache_addr),
        .cache_wr_data     (cache_wr_data),
        .cache_wr_be       (cache_wr_be),
        .cache_data        (cache_data),
        .cache_waitrequest (cache_waitrequest),
        .grant_valid       (grant_valid),
        .grant_idx         (grant_idx),
        .contention_cnt    (contention_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a0,
                         input logic [31:0] a1, input logic cw, input logic [31:0] cd);
        req_rd            = rd;
        req_wr            = wr;
        req_addr[0]       = a0;
        req_addr[1]       = a1;
        cache_waitrequest = cw;
        cache_data        = cd;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a0,
                        input logic [31:0] a1, input logic cw, input logic [31:0] cd);
        @(negedge clock);
        drive(rd, wr, a0, a1, cw, cd);
        #2;
    endtask

    initial begin
        req_wr_data[0] = D0;
        req_wr_data[1] = D1;
        req_wr_be[0]   = 4'h3;
        req_wr_be[1]   = 4'hF;
        vecs[0]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b0, 32'h0,         2'b11, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 16'd0};
        vecs[1]  = '{2'b01, 2'b00, 32'h100, 32'h0,   1'b0, 32'hCAFE_0001, 2'b10, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{2'b11, 2'b00, 32'h200, 32'h300, 1'b0, 32'hCAFE_0002, 2'b01, 1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 16'd0};
        vecs[3]  = '{2'b01, 2'b00, 32'h200, 32'h0,   1'b0, 32'hCAFE_0003, 2'b10, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 16'd1};
        vecs[4]  = '{2'b00, 2'b10, 32'h0,   32'h400, 1'b1, 32'h0,         2'b11, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 16'd1};
        vecs[5]  = '{2'b01, 2'b10, 32'h500, 32'h400, 1'b1, 32'h0,         2'b11, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 16'd1};
        vecs[6]  = '{2'b01, 2'b10, 32'h500, 32'h400, 1'b0, 32'h0,         2'b01, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 16'd2};
        vecs[7]  = '{2'b01, 2'b00, 32'h500, 32'h0,   1'b0, 32'hCAFE_0007, 2'b10, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 16'd3};
        vecs[8]  = '{2'b01, 2'b00, 32'h600, 32'h0,   1'b1, 32'h0,         2'b11, 1'b1, 1'b0, 32'h600, 1'b1, 1'b0, 16'd3};
        vecs[9]  = '{2'b10, 2'b00, 32'h0,   32'h700, 1'b0, 32'h0,         2'b11, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 16'd3};
        vecs[10] = '{2'b10, 2'b00, 32'h0,   32'h700, 1'b0, 32'hCAFE_000A, 2'b01, 1'b1, 1'b0, 32'h700, 1'b1, 1'b1, 16'd4};
        vecs[11] = '{2'b01, 2'b01, 32'h800, 32'h0,   1'b0, 32'h0,         2'b10, 1'b0, 1'b1, 32'h800, 1'b1, 1'b0, 16'd4};
        vecs[12] = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b0, 32'h0,         2'b11, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 16'd4};

        drive(2'b01, 2'b00, 32'h40, 32'h0, 1'b0, 32'h0);
        #7;
        chk("in_reset wreq", 32'(req_waitrequest), 32'h3);
        chk("in_reset cache_rd", 32'(cache_rd), 32'h0);
        chk("in_reset gv", 32'(grant_valid), 32'h0);
        chk("in_reset addr", cache_addr, 32'h0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].a0, vecs[i].a1, vecs[i].cw, vecs[i].cd);
            chk($sformatf("v%0d wreq", i), 32'(req_waitrequest), 32'(vecs[i].wreq));
            chk($sformatf("v%0d cache_rd", i), 32'(cache_rd), 32'(vecs[i].crd));
            chk($sformatf("v%0d cache_wr", i), 32'(cache_wr), 32'(vecs[i].cwr));
            chk($sformatf("v%0d addr", i), cache_addr, vecs[i].addr);
            chk($sformatf("v%0d gv", i), 32'(grant_valid), 32'(vecs[i].gv));
            chk($sformatf("v%0d gidx", i), 32'(grant_idx), 32'(vecs[i].gi));
            chk($sformatf("v%0d cnt", i), 32'(contention_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d req_data", i), req_data, vecs[i].cd);
            chk($sformatf("v%0d wr_data", i), cache_wr_data, !vecs[i].gv ? 32'h0 : vecs[i].gi ? D1 : D0);
            chk($sformatf("v%0d wr_be", i), 32'(cache_wr_be), !vecs[i].gv ? 32'h0 : vecs[i].gi ? 32'hF : 32'h3);
        end

        do_reset();
        step(2'b11, 2'b00, 32'hA0, 32'hB0, 1'b0, 32'h0);
        chk("simul c1 wreq", 32'(req_waitrequest), 32'h2);
        chk("simul c1 addr", cache_addr, 32'hA0);
        step(2'b10, 2'b00, 32'h0, 32'hB0, 1'b0, 32'h0);
        chk("simul c2 wreq", 32'(req_waitrequest), 32'h1);
        chk("simul c2 addr", cache_addr, 32'hB0);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("simul cnt", 32'(contention_cnt), 32'd1);

        do_reset();
        step(2'b00, 2'b10, 32'h0, 32'h1000, 1'b1, 32'h0);
        chk("lock c1 gidx", 32'(grant_idx), 32'h1);
        chk("lock c1 wr_data", cache_wr_data, D1);
        chk("lock c1 wr_be", 32'(cache_wr_be), 32'hF);
        for (int c = 2; c <= 3; c++) begin
            step(2'b01, 2'b10, 32'h2000, 32'h1000, 1'b1, 32'h0);
            chk($sformatf("lock c%0d wreq", c), 32'(req_waitrequest), 32'h3);
            chk($sformatf("lock c%0d addr", c), cache_addr, 32'h1000);
        end
        step(2'b01, 2'b10, 32'h2000, 32'h1000, 1'b0, 32'h0);
        chk("lock c4 wreq", 32'(req_waitrequest), 32'h1);
        chk("lock c4 gidx", 32'(grant_idx), 32'h1);
        step(2'b01, 2'b00, 32'h2000, 32'h0, 1'b0, 32'h0);
        chk("lock c5 wreq", 32'(req_waitrequest), 32'h2);
        chk("lock c5 addr", cache_addr, 32'h2000);
        chk("lock c5 cnt", 32'(contention_cnt), 32'd3);

        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 2'b00, 32'hC0, 32'hC4, 1'b0, 32'h0);
            chk($sformatf("alt %0d gidx", k), 32'(grant_idx), 32'(k % 2));
            chk($sformatf("alt %0d wreq", k), 32'(req_waitrequest), (k % 2) ? 32'h1 : 32'h2);
        end

        step(2'b00, 2'b10, 32'h0, 32'h900, 1'b1, 32'h0);
        step(2'b00, 2'b10, 32'h0, 32'h900, 1'b1, 32'h0);
        chk("abort locked gidx", 32'(grant_idx), 32'h1);
        chk("abort locked wr", 32'(cache_wr), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort wr", 32'(cache_wr), 32'h0);
        chk("abort wreq", 32'(req_waitrequest), 32'h3);
        chk("abort gv", 32'(grant_valid), 32'h0);
        chk("abort gidx", 32'(grant_idx), 32'h0);
        chk("abort addr", cache_addr, 32'h0);
        chk("abort cnt", 32'(contention_cnt), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(2'b01, 2'b10, 32'hA00, 32'h900, 1'b0, 32'h0);
        #2;
        chk("post_abort gidx", 32'(grant_idx), 32'h0);
        chk("post_abort wreq", 32'(req_waitrequest), 32'h2);
        chk("post_abort addr", cache_addr, 32'hA00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
